// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared encodings and defaults for the memory port arbiter
package core_pkg;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    localparam int MEM_LAT_DEFAULT = 2;
    localparam int CNT_W           = 4;

    // With rr_en, contention goes to whoever was not granted last; otherwise LS wins.
    function automatic owner_e pick_winner(input logic if_req, input logic ls_req,
                                           input owner_e last, input logic rr_en);
        owner_e w;
        if (if_req && ls_req) begin
            if (rr_en && (last == OWN_LS)) w = OWN_IF;
            else                           w = OWN_LS;
        end else if (ls_req) begin
            w = OWN_LS;
        end else begin
            w = OWN_IF;
        end
        return w;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory signals of the shared memory port
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_if_req;
    logic [ADDR_W-1:0] i_if_addr;
    logic              o_if_gnt;
    logic              o_if_valid;
    logic [DATA_W-1:0] o_if_rdata;
    logic              o_if_err;

    logic                i_ls_req;
    logic                i_ls_wen;
    logic [ADDR_W-1:0]   i_ls_addr;
    logic [DATA_W-1:0]   i_ls_wdata;
    logic [DATA_W/8-1:0] i_ls_mask;
    logic                o_ls_gnt;
    logic                o_ls_valid;
    logic [DATA_W-1:0]   o_ls_rdata;

    logic                o_mem_req;
    logic                o_mem_wen;
    logic [ADDR_W-1:0]   o_mem_addr;
    logic [DATA_W-1:0]   o_mem_wdata;
    logic [DATA_W/8-1:0] o_mem_mask;
    logic [DATA_W-1:0]   i_mem_rdata;

    modport slave (
        input  i_if_req, i_if_addr,
        output o_if_gnt, o_if_valid, o_if_rdata, o_if_err,
        input  i_ls_req, i_ls_wen, i_ls_addr, i_ls_wdata, i_ls_mask,
        output o_ls_gnt, o_ls_valid, o_ls_rdata,
        output o_mem_req, o_mem_wen, o_mem_addr, o_mem_wdata, o_mem_mask,
        input  i_mem_rdata
    );

    modport master (
        output i_if_req, i_if_addr,
        input  o_if_gnt, o_if_valid, o_if_rdata, o_if_err,
        output i_ls_req, i_ls_wen, i_ls_addr, i_ls_wdata, i_ls_mask,
        input  o_ls_gnt, o_ls_valid, o_ls_rdata,
        input  o_mem_req, o_mem_wen, o_mem_addr, o_mem_wdata, o_mem_mask,
        output i_mem_rdata
    );
endinterface

// File: rtl/arb_lat_cnt.sv
// rtl/arb_lat_cnt.sv - loadable down-counter with zero flag tracking memory latency
module arb_lat_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         zero
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/LS arbiter for the single memory port, one access in flight
// Optional build macro ARB_ROUND_ROBIN_EN selects round-robin arbitration on contention.
module mem_port_arbiter
    import core_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_halt,
    output logic o_busy,
    mem_port_arbiter_if.slave bus
);

`ifdef ARB_ROUND_ROBIN_EN
    localparam logic RR_EN = 1'b1;
`else
    localparam logic RR_EN = 1'b0;
`endif

    arb_state_e       state_q, state_d;
    owner_e           owner_q, owner_d;
    owner_e           last_q, last_d;
    logic             store_q, store_d;
    owner_e           winner;
    logic             misaligned;
    logic             cnt_load;
    logic             cnt_zero;
    logic [CNT_W-1:0] cnt;

    arb_lat_cnt #(.W(CNT_W)) u_lat_cnt (
        .clk      (i_clk),
        .rst_n    (i_rst),
        .load     (cnt_load),
        .load_val (CNT_W'(MEM_LAT - 1)),
        .en       (state_q == ARB_BUSY),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= ARB_IDLE;
            owner_q <= OWN_IF;
            last_q  <= OWN_IF;
            store_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            store_q <= store_d;
        end
    end

    assign winner     = pick_winner(bus.i_if_req, bus.i_ls_req, last_q, RR_EN);
    assign misaligned = (bus.i_if_addr[1:0] != 2'b00);

    // Outputs are gated by reset so that every output reads 0 while rst is held low.
    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        last_d          = last_q;
        store_d         = store_q;
        cnt_load        = 1'b0;
        bus.o_if_gnt    = 1'b0;
        bus.o_if_valid  = 1'b0;
        bus.o_if_rdata  = '0;
        bus.o_if_err    = 1'b0;
        bus.o_ls_gnt    = 1'b0;
        bus.o_ls_valid  = 1'b0;
        bus.o_ls_rdata  = '0;
        bus.o_mem_req   = 1'b0;
        bus.o_mem_wen   = 1'b0;
        bus.o_mem_addr  = '0;
        bus.o_mem_wdata = '0;
        bus.o_mem_mask  = '0;
        o_busy          = i_rst && (state_q == ARB_BUSY);

        if (i_rst) begin
            case (state_q)
                ARB_IDLE: begin
                    if (!i_halt && (bus.i_if_req || bus.i_ls_req)) begin
                        last_d = winner;
                        if (winner == OWN_IF) begin
                            bus.o_if_gnt = 1'b1;
                            if (misaligned) begin
                                bus.o_if_err = 1'b1;
                            end else begin
                                bus.o_mem_req  = 1'b1;
                                bus.o_mem_addr = bus.i_if_addr;
                                bus.o_mem_mask = '1;
                                state_d        = ARB_BUSY;
                                owner_d        = OWN_IF;
                                store_d        = 1'b0;
                                cnt_load       = 1'b1;
                            end
                        end else begin
                            bus.o_ls_gnt    = 1'b1;
                            bus.o_mem_req   = 1'b1;
                            bus.o_mem_wen   = bus.i_ls_wen;
                            bus.o_mem_addr  = bus.i_ls_addr;
                            bus.o_mem_wdata = bus.i_ls_wdata;
                            bus.o_mem_mask  = bus.i_ls_mask;
                            state_d         = ARB_BUSY;
                            owner_d         = OWN_LS;
                            store_d         = bus.i_ls_wen;
                            cnt_load        = 1'b1;
                        end
                    end
                end
                ARB_BUSY: begin
                    if (cnt_zero) begin
                        state_d = ARB_IDLE;
                        if (owner_q == OWN_IF) begin
                            bus.o_if_valid = 1'b1;
                            bus.o_if_rdata = bus.i_mem_rdata;
                        end else begin
                            bus.o_ls_valid = 1'b1;
                            bus.o_ls_rdata = store_q ? '0 : bus.i_mem_rdata;
                        end
                    end
                end
                default: state_d = ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed bench with a transaction-level model checked every cycle
module tb_mem_port_arbiter;

    localparam int MEM_LAT = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic halt;
    logic busy;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT)) dut (
        .i_clk  (clk),
        .i_rst  (rst_n),
        .i_halt (halt),
        .o_busy (busy),
        .bus    (bus_if)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [int];
    logic [31:0] rsp [int];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(int'(a >> 2))) return mem[int'(a >> 2)];
        return {a[15:0] ^ 16'hA5A5, a[15:0]};
    endfunction

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endfunction

    // Memory returns the scheduled word exactly MEM_LAT cycles after a request, garbage otherwise.
    always @(posedge clk) begin
        cyc++;
        #1;
        bus_if.i_mem_rdata = rsp.exists(cyc) ? rsp[cyc] : (32'hBAD0_0000 | 32'(cyc));
    end

    // Model: at most one access in flight, valid due MEM_LAT cycles after its grant.
    bit          m_busy = 0;
    int          m_due = 0;
    bit          m_own_ls = 0;
    bit          m_store = 0;
    bit          m_last_ls = 0;
    logic [31:0] m_rdata = '0;

    always @(negedge clk) begin
        logic        e_ig, e_ie, e_iv, e_lg, e_lv, e_mr, e_mw, e_busy;
        logic [31:0] e_ir, e_lr, e_ma, e_md, wr;
        logic [3:0]  e_mm;
        bit          grant, w_ls;
        e_ig = 0; e_ie = 0; e_iv = 0; e_lg = 0; e_lv = 0; e_mr = 0; e_mw = 0; e_busy = 0;
        e_ir = 0; e_lr = 0; e_ma = 0; e_md = 0; e_mm = 0; grant = 0; w_ls = 0;
        if (!rst_n) begin
            m_busy    = 0;
            m_last_ls = 0;
        end else begin
            if (m_busy && cyc == m_due) begin
                if (m_own_ls) begin e_lv = 1; e_lr = m_store ? 32'h0 : m_rdata; end
                else          begin e_iv = 1; e_ir = m_rdata; end
            end
            e_busy = m_busy;
            if (!m_busy && !halt && (bus_if.i_if_req || bus_if.i_ls_req)) begin
                if (bus_if.i_if_req && bus_if.i_ls_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                    w_ls = !m_last_ls;
`else
                    w_ls = 1;
`endif
                end else begin
                    w_ls = bus_if.i_ls_req;
                end
                m_last_ls = w_ls;
                if (!w_ls) begin
                    e_ig = 1;
                    if (bus_if.i_if_addr[1:0] != 2'b00) e_ie = 1;
                    else begin e_mr = 1; e_ma = bus_if.i_if_addr; e_mm = 4'hF; grant = 1; end
                end else begin
                    e_lg = 1; e_mr = 1; e_mw = bus_if.i_ls_wen; e_ma = bus_if.i_ls_addr;
                    e_md = bus_if.i_ls_wdata; e_mm = bus_if.i_ls_mask; grant = 1;
                end
            end
        end
        chk("if_gnt", 64'(bus_if.o_if_gnt), 64'(e_ig));
        chk("if_err", 64'(bus_if.o_if_err), 64'(e_ie));
        chk("if_valid", 64'(bus_if.o_if_valid), 64'(e_iv));
        chk("if_rdata", 64'(bus_if.o_if_rdata), 64'(e_ir));
        chk("ls_gnt", 64'(bus_if.o_ls_gnt), 64'(e_lg));
        chk("ls_valid", 64'(bus_if.o_ls_valid), 64'(e_lv));
        chk("ls_rdata", 64'(bus_if.o_ls_rdata), 64'(e_lr));
        chk("mem_req", 64'(bus_if.o_mem_req), 64'(e_mr));
        chk("mem_wen", 64'(bus_if.o_mem_wen), 64'(e_mw));
        chk("mem_addr", 64'(bus_if.o_mem_addr), 64'(e_ma));
        chk("mem_wdata", 64'(bus_if.o_mem_wdata), 64'(e_md));
        chk("mem_mask", 64'(bus_if.o_mem_mask), 64'(e_mm));
        chk("busy", 64'(busy), 64'(e_busy));
        if (rst_n) begin
            if (m_busy && cyc == m_due) m_busy = 0;
            if (grant) begin
                m_busy   = 1;
                m_due    = cyc + MEM_LAT;
                m_own_ls = w_ls;
                m_store  = w_ls && bus_if.i_ls_wen;
                if (m_store) begin
                    wr = mem_rd(e_ma);
                    for (int b = 0; b < 4; b++)
                        if (e_mm[b]) wr[8*b +: 8] = e_md[8*b +: 8];
                    mem[int'(e_ma >> 2)] = wr;
                end else begin
                    m_rdata     = mem_rd(e_ma);
                    rsp[m_due]  = m_rdata;
                end
            end
        end
    end

    function automatic logic sig(input int which);
        case (which)
            0:       return bus_if.o_if_gnt;
            1:       return bus_if.o_ls_gnt;
            2:       return bus_if.o_if_valid;
            3:       return bus_if.o_ls_valid;
            default: return bus_if.o_if_gnt | bus_if.o_ls_gnt;
        endcase
    endfunction

    task automatic wait_sig(input int which, input string nm, output int at);
        at = -1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (sig(which)) begin at = cyc; break; end
        end
        if (at < 0) begin
            n_chk++; n_fail++;
            $display("FAIL %s: timeout waiting, got none expected event", nm);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    int t, at, start;
    bit exp_if_second;

    initial begin
        mem[int'(32'h100 >> 2)] = 32'h0000_0013;
        rst_n = 0; halt = 0;
        bus_if.i_if_req = 1; bus_if.i_if_addr = 32'h100;
        bus_if.i_ls_req = 1; bus_if.i_ls_wen = 0; bus_if.i_ls_addr = 32'h200;
        bus_if.i_ls_wdata = 0; bus_if.i_ls_mask = 4'hF; bus_if.i_mem_rdata = 0;

        // reset holds every output low even with requests pending
        repeat (2) @(negedge clk);
        chk("rst_if_gnt", 64'(bus_if.o_if_gnt), 64'h0);
        chk("rst_ls_gnt", 64'(bus_if.o_ls_gnt), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        next_cycle();
        rst_n = 1; bus_if.i_if_req = 0; bus_if.i_ls_req = 0;
        next_cycle();

        // 1: IF-only read at 0x100, back-to-back fetch
        bus_if.i_if_req = 1; bus_if.i_if_addr = 32'h100; start = cyc;
        wait_sig(0, "t1_gnt", t);
        chk("t1_gnt_cycle", 64'(t), 64'(start));
        next_cycle();
        bus_if.i_if_addr = 32'h104;
        wait_sig(2, "t1_valid", at);
        chk("t1_valid_lat", 64'(at - t), 64'd2);
        chk("t1_rdata", 64'(bus_if.o_if_rdata), 64'h13);
        wait_sig(0, "t1_gnt2", at);
        chk("t1_next_gnt", 64'(at - t), 64'd3);
        next_cycle();
        bus_if.i_if_req = 0;
        repeat (3) next_cycle();

        // 2: contention between IF and LS
        bus_if.i_if_req = 1; bus_if.i_if_addr = 32'h300;
        bus_if.i_ls_req = 1; bus_if.i_ls_wen = 0; bus_if.i_ls_addr = 32'h200; start = cyc;
        wait_sig(1, "t2_ls_gnt", t);
        chk("t2_first_ls", 64'(t), 64'(start));
        next_cycle();
        bus_if.i_ls_addr = 32'h204;
        wait_sig(4, "t2_gnt2", at);
        chk("t2_gnt2_cycle", 64'(at - t), 64'd3);
`ifdef ARB_ROUND_ROBIN_EN
        exp_if_second = 1;
`else
        exp_if_second = 0;
`endif
        chk("t2_gnt2_is_if", 64'(bus_if.o_if_gnt), 64'(exp_if_second));
        next_cycle();
        if (exp_if_second) bus_if.i_if_req = 0; else bus_if.i_ls_req = 0;
        wait_sig(exp_if_second ? 1 : 0, "t2_gnt3", at);
        chk("t2_gnt3_cycle", 64'(at - t), 64'd6);
        next_cycle();
        bus_if.i_if_req = 0; bus_if.i_ls_req = 0;
        repeat (3) next_cycle();

        // 3: LS store
        bus_if.i_ls_req = 1; bus_if.i_ls_wen = 1; bus_if.i_ls_addr = 32'h40;
        bus_if.i_ls_wdata = 32'hDEAD_BEEF; bus_if.i_ls_mask = 4'b0011;
        wait_sig(1, "t3_gnt", t);
        chk("t3_mem_wen", 64'(bus_if.o_mem_wen), 64'h1);
        chk("t3_mem_mask", 64'(bus_if.o_mem_mask), 64'h3);
        next_cycle();
        bus_if.i_ls_req = 0; bus_if.i_ls_wen = 0; bus_if.i_ls_mask = 4'hF;
        wait_sig(3, "t3_valid", at);
        chk("t3_valid_lat", 64'(at - t), 64'd2);
        chk("t3_rdata_zero", 64'(bus_if.o_ls_rdata), 64'h0);
        next_cycle();
        // read back the partially written word
        bus_if.i_ls_req = 1; bus_if.i_ls_addr = 32'h40;
        wait_sig(1, "t3_rd_gnt", t);
        next_cycle();
        bus_if.i_ls_req = 0;
        wait_sig(3, "t3_rd_valid", at);
        chk("t3_readback", 64'(bus_if.o_ls_rdata), 64'hA5E5_BEEF);
        repeat (2) next_cycle();

        // 4: misaligned fetch
        bus_if.i_if_req = 1; bus_if.i_if_addr = 32'h102;
        wait_sig(0, "t4_gnt", t);
        chk("t4_err", 64'(bus_if.o_if_err), 64'h1);
        chk("t4_no_mem_req", 64'(bus_if.o_mem_req), 64'h0);
        next_cycle();
        bus_if.i_if_req = 0;
        @(negedge clk);
        chk("t4_not_busy", 64'(busy), 64'h0);
        repeat (2) next_cycle();

        // 5: halt raised during BUSY
        bus_if.i_if_req = 1; bus_if.i_if_addr = 32'h108;
        wait_sig(0, "t5_gnt", t);
        next_cycle();
        halt = 1; bus_if.i_if_addr = 32'h10C;
        wait_sig(2, "t5_valid", at);
        chk("t5_completes", 64'(at - t), 64'd2);
        next_cycle();
        @(negedge clk);
        chk("t5_halted_no_gnt", 64'(bus_if.o_if_gnt), 64'h0);
        next_cycle();
        halt = 0; start = cyc;
        wait_sig(0, "t5_gnt2", at);
        chk("t5_gnt_after_halt", 64'(at), 64'(start));
        next_cycle();
        bus_if.i_if_req = 0;
        repeat (3) next_cycle();

        // 6: reset in the middle of a load
        bus_if.i_ls_req = 1; bus_if.i_ls_wen = 0; bus_if.i_ls_addr = 32'h200;
        wait_sig(1, "t6_gnt", t);
        next_cycle();
        bus_if.i_ls_req = 0; rst_n = 0;
        @(negedge clk);
        chk("t6_busy_cleared", 64'(busy), 64'h0);
        next_cycle();
        @(negedge clk);
        chk("t6_no_valid", 64'(bus_if.o_ls_valid), 64'h0);
        next_cycle();
        rst_n = 1;
        @(negedge clk);
        chk("t6_idle_after", 64'(busy), 64'h0);
        next_cycle();
        bus_if.i_if_req = 1; bus_if.i_if_addr = 32'h110; start = cyc;
        wait_sig(0, "t6_gnt_after", at);
        chk("t6_gnt_after_cycle", 64'(at), 64'(start));
        next_cycle();
        bus_if.i_if_req = 0;
        repeat (4) next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
